// File: rtl/seg_pkg.sv
// Shared 7-segment constants for the display capture path.
// Patterns are active-high, bit 6 = segment a down to bit 0 = segment g.
package seg_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Element k holds the glyph for hex digit k.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment glyph decoder: active-high abcdefg pattern to
// hex nibble, with flags for an all-off digit and an unrecognised glyph.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_blank,
    output logic       o_err
);

    logic w_hit;

    always_comb begin
        o_nibble = 4'd0;
        o_blank  = 1'b0;
        o_err    = 1'b0;
        w_hit    = 1'b0;
        if (i_seg == SEG_BLANK) begin
            o_blank = 1'b1;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (i_seg == SEG_HEX[k]) begin
                    o_nibble = 4'(k);
                    w_hit    = 1'b1;
                end
            end
            o_err = ~w_hit;
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Receiver for a multiplexed 7-segment bus: samples each digit once it has
// been stable, and publishes the complete frame as a parallel word.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int NDIG       = 8,
    parameter int SETTLE     = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        a_to_g,
    input  logic [NDIG-1:0]   an,
    input  logic              dp,
    output logic [4*NDIG-1:0] value,
    output logic [NDIG-1:0]   dp_mask,
    output logic [NDIG-1:0]   blank_mask,
    output logic [NDIG-1:0]   err_mask,
    output logic              frame_valid,
    output logic              frame_changed
);

    localparam int             BW       = NDIG + 8;
    localparam int             CW       = $clog2(SETTLE);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(SETTLE - 1);
    localparam logic [BW-1:0]  INV_MASK = (ACTIVE_LOW != 0) ? {BW{1'b1}} : {BW{1'b0}};

    logic [BW-1:0]     r_bus_p0;
    logic [BW-1:0]     r_bus_p1;
    logic [CW-1:0]     r_cnt;
    logic              r_captured;
    logic              r_pub_pend;
    logic [NDIG-1:0]   r_seen;
    logic [4*NDIG-1:0] r_sh_val;
    logic [NDIG-1:0]   r_sh_dp;
    logic [NDIG-1:0]   r_sh_blank;
    logic [NDIG-1:0]   r_sh_err;

    logic [NDIG-1:0]   w_an;
    logic [6:0]        w_seg;
    logic              w_dp;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic              w_err;
    logic              w_same;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_capture;
    logic [NDIG-1:0]   w_seen_nxt;
    logic [7*NDIG-1:0] w_shadow_set;
    logic [7*NDIG-1:0] w_out_set;

    // Stage p0: register the raw bus and normalise to active-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_p0 <= '0;
        end else begin
            r_bus_p0 <= {an, a_to_g, dp} ^ INV_MASK;
        end
    end

    assign w_an  = r_bus_p0[BW-1 -: NDIG];
    assign w_seg = r_bus_p0[7:1];
    assign w_dp  = r_bus_p0[0];

    seg7_decode u_dec (
        .i_seg    (w_seg),
        .o_nibble (w_nib),
        .o_blank  (w_blank),
        .o_err    (w_err)
    );

    assign w_same = (r_bus_p0 == r_bus_p1);

    always_comb begin
        w_cnt_nxt = '0;
        if (w_same) begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
    end

    // A dwell captures exactly once, on the cycle its count first reaches the limit.
    assign w_capture    = w_same && (w_cnt_nxt == CNT_MAX) && !r_captured
                          && is_onehot(32'(w_an));
    assign w_seen_nxt   = r_seen | (w_capture ? w_an : '0);
    assign w_shadow_set = {r_sh_val, r_sh_dp, r_sh_blank, r_sh_err};
    assign w_out_set    = {value, dp_mask, blank_mask, err_mask};

    // Stage p1: stability tracking, shadow capture and frame publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_p1      <= '0;
            r_cnt         <= '0;
            r_captured    <= 1'b0;
            r_pub_pend    <= 1'b0;
            r_seen        <= '0;
            r_sh_val      <= '0;
            r_sh_dp       <= '0;
            r_sh_blank    <= '0;
            r_sh_err      <= '0;
            value         <= '0;
            dp_mask       <= '0;
            blank_mask    <= '0;
            err_mask      <= '0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
        end else begin
            r_bus_p1   <= r_bus_p0;
            r_cnt      <= w_cnt_nxt;
            r_captured <= w_same && (r_captured || w_capture);
            r_pub_pend <= w_capture && (w_seen_nxt == {NDIG{1'b1}});
            r_seen     <= r_pub_pend ? '0 : w_seen_nxt;
            for (int i = 0; i < NDIG; i++) begin
                if (w_capture && w_an[i]) begin
                    r_sh_val[4*i +: 4] <= w_nib;
                    r_sh_dp[i]         <= w_dp;
                    r_sh_blank[i]      <= w_blank;
                    r_sh_err[i]        <= w_err;
                end
            end
            frame_valid   <= r_pub_pend;
            frame_changed <= r_pub_pend && (w_shadow_set != w_out_set);
            if (r_pub_pend) begin
                value      <= r_sh_val;
                dp_mask    <= r_sh_dp;
                blank_mask <= r_sh_blank;
                err_mask   <= r_sh_err;
            end
        end
    end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Monitors the multiplexed 7-segment bus (`a_to_g`, `an`, `dp`) that the ALU display path drives.
- Reconstructs the hex value shown on the display and publishes it as a parallel word with a frame strobe.
- Acts as the receiver/decoder end of the display driver. Used for on-chip self-check and for the display testbenches, so they can compare the displayed result against `led` directly.

Parameters:
- NDIG, 8, number of digits/anodes scanned.
- SETTLE, 4, consecutive identical cycles required before a digit is sampled (min 2).
- ACTIVE_LOW, 1, 1 = anodes and segments active-low (board default); 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- a_to_g  in  7  segment bus; bit 6 = a … bit 0 = g.
- an  in  NDIG  anode enables; an[i] selects digit i.
- dp  in  1  decimal point.
- value  out  4*NDIG  decoded digits; digit i at value[4i+3:4i].
- dp_mask  out  NDIG  per-digit dp lit.
- blank_mask  out  NDIG  per-digit all segments off.
- err_mask  out  NDIG  per-digit unrecognised segment pattern.
- frame_valid  out  1  one-cycle pulse when a new full frame is published.
- frame_changed  out  1  one-cycle pulse, coincident with frame_valid, when value/masks differ from the previous frame.

Behaviour:
- Reset: all outputs 0; shadow registers, seen bits, stability counter and captured flag cleared.
  - Reset mid-frame discards the partial frame.
  - The first frame after reset asserts frame_changed only if its contents are nonzero.
- Input stage: {an, a_to_g, dp} registered once. If ACTIVE_LOW, inverted internally so all further logic is active-high.
- Stability counter:
  - If the registered bus equals its previous value, cnt increments, saturating at SETTLE-1.
  - Otherwise cnt = 0 and captured = 0.
- Capture condition: cnt reaches SETTLE-1, captured = 0, and an is exactly one-hot.
  - Write decoded nibble, dp, blank and err into shadow slot i.
  - Set seen[i] and captured = 1, so each dwell captures once.
- Invalid anodes: zero or multiple active anodes are ignored; no capture.
- Repeated digit: a digit captured again before the frame completes overwrites its slot (latest wins).
- Decode (active-high, abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - All-off gives nibble 0 and blank=1.
  - Any other pattern gives nibble 0 and err=1.
- Publish: on the cycle after the capture that makes seen all-ones:
  - value and all masks load from shadow.
  - frame_valid = 1 for one cycle.
  - frame_changed = 1 if {value, dp_mask, blank_mask, err_mask} differs from the prior published set.
  - seen is cleared in the same cycle.
- Latency: raw bus change to capture = 1 (input register) + SETTLE cycles. Final capture to frame_valid = 1 cycle.
- Outputs hold between frames; the block never generates a timeout.

Decomposition:
- Package seg_pkg:
  - SEG_A…SEG_G bit-index constants.
  - Localparam table of the 16 hex segment patterns.
  - SEG_BLANK constant.
- Sub-module seg7_decode: purely combinational; 7-bit active-high pattern -> {nibble[3:0], blank, err}. Shared with any future display-side checker.
- All sequential logic stays in seg_scan_capture.

Test Plan:
1. Reset: rst=1 for 2 cycles -> value=0, all masks 0, frame_valid=0, frame_changed=0.
2. Scan "12345678" (digit i shows hex 8-i, so digit 7 = 1), active-low, dwell 8 cycles per digit, i=0..7:
   - One frame_valid pulse 1 cycle after the digit-7 capture.
   - value=32'h12345678 and frame_changed=1.
   - An identical second scan gives frame_valid=1, frame_changed=0.
3. Glitch: digit 2 shown for 3 cycles (< SETTLE) then moved on -> no capture, no frame_valid. The frame completes only after digit 2 is shown for ≥4 stable cycles.
4. an=8'b11111100 (two active, active-low) held 10 cycles -> no seen bit set.
5. Digit 5 = 7'b1111111 (active-low blank) and digit 3 = active-high 0110110 (unknown):
   - blank_mask[5]=1, err_mask[3]=1.
   - Nibbles 5 and 3 = 0.
   - Other digits decode correctly.
6. rst asserted for 1 cycle after 4 digits captured -> seen cleared. A frame_valid pulse requires 8 fresh captures; no pulse after only the remaining 4.
